// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: func3 codes, FSM states
// and access-size helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} lsu_state_t;

  // size code is func3[1:0]; 2'b11 only occurs on illegal requests
  function automatic logic [2:0] size_bytes(input logic [1:0] szc);
    case (szc)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] szc);
    case (szc)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute-side request, data-memory port and writeback completion bundle.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_err;

  // master: the controller; slave: execute stage + memory + writeback
  modport master (
    input  req_valid, req_we, req_func3, req_addr, req_wdata, req_rd,
           mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
           resp_valid, resp_rd, resp_data, resp_err
  );

  modport slave (
    output req_valid, req_we, req_func3, req_addr, req_wdata, req_rd,
           mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
           resp_valid, resp_rd, resp_data, resp_err
  );
endinterface

// File: rtl/lsu_ctrl_load_ext.sv
// Load result extension: picks byte/half/word from the merged word and
// sign- or zero-extends it; illegal func3 yields zero.
module load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [31:0] din,
  output logic [31:0] dout
);
  always_comb begin
    dout = '0;
    case (func3)
      F3_B:    dout = {{24{din[7]}}, din[7:0]};
      F3_H:    dout = {{16{din[15]}}, din[15:0]};
      F3_W:    dout = din;
      F3_BU:   dout = {24'b0, din[7:0]};
      F3_HU:   dout = {16'b0, din[15:0]};
      default: dout = '0;
    endcase
  end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one request in, one or two word accesses out,
// one completion back. All outputs come straight from flops.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  lsu_ctrl_if.master bus
);
  lsu_state_t  state_q, state_n;
  logic [31:0] addr_q, wdata_q, rdata0_q, rdata1_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [4:0]  rd_q;

  logic        ready_q, mreq_q, mwe_q, rvld_q, rerr_q;
  logic [31:0] maddr_q, mwdata_q, rdata_q;
  logic [3:0]  mstrb_q;
  logic [4:0]  rrd_q;

  logic        idle, accept, legal, split;
  logic [31:0] a_addr, a_wdata, base, rd0_n, rd1_n, merged, ext;
  logic [2:0]  a_f3, sz;
  logic        a_we;
  logic [4:0]  a_rd;
  logic [1:0]  off;
  logic [63:0] lanes;
  logic [7:0]  strb8;
  logic [55:0] pair;

  // In IDLE the incoming request is the one being decoded, so the first
  // access's outputs can be registered on the accept edge itself.
  always_comb begin
    idle    = (state_q == IDLE);
    accept  = idle && bus.req_valid;
    a_addr  = idle ? bus.req_addr  : addr_q;
    a_wdata = idle ? bus.req_wdata : wdata_q;
    a_f3    = idle ? bus.req_func3 : f3_q;
    a_we    = idle ? bus.req_we    : we_q;
    a_rd    = idle ? bus.req_rd    : rd_q;
    off     = a_addr[1:0];
    sz      = size_bytes(a_f3[1:0]);
    split   = ({2'b00, off} + {1'b0, sz}) > 4'd4;
    legal   = f3_legal(a_we, a_f3);
    base    = {a_addr[31:2], 2'b00};
    lanes   = {32'b0, a_wdata} << {off, 3'b000};
    strb8   = {4'b0000, size_mask(a_f3[1:0])} << off;
  end

  // Forward read data arriving this cycle so the response sees it on the
  // same edge the FSM moves into RESP.
  always_comb begin
    rd0_n = (state_q == WAIT0 && bus.mem_rvalid) ? bus.mem_rdata : rdata0_q;
    rd1_n = (state_q == WAIT1 && bus.mem_rvalid) ? bus.mem_rdata : rdata1_q;
    pair  = split ? {rd1_n[23:0], rd0_n} : {24'b0, rd0_n};
    case (off)
      2'd0:    merged = pair[31:0];
      2'd1:    merged = pair[39:8];
      2'd2:    merged = pair[47:16];
      default: merged = pair[55:24];
    endcase
  end

  load_ext u_ext (.func3(a_f3), .din(merged), .dout(ext));

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:  if (accept) state_n = legal ? REQ0 : RESP;
      REQ0:  if (bus.mem_gnt) state_n = !a_we ? WAIT0 : (split ? REQ1 : RESP);
      WAIT0: if (bus.mem_rvalid) state_n = split ? REQ1 : RESP;
      REQ1:  if (bus.mem_gnt) state_n = a_we ? RESP : WAIT1;
      WAIT1: if (bus.mem_rvalid) state_n = RESP;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ready_q  <= 1'b1;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mstrb_q  <= '0;
      mwdata_q <= '0;
      rvld_q   <= 1'b0;
      rrd_q    <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      rdata0_q <= rd0_n;
      rdata1_q <= rd1_n;
      ready_q  <= (state_n == IDLE);
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        f3_q    <= bus.req_func3;
        we_q    <= bus.req_we;
        rd_q    <= bus.req_rd;
      end
      // Request fields are recomputed from latched state every cycle, so they
      // stay constant while waiting for a grant.
      case (state_n)
        REQ0: begin
          mreq_q   <= 1'b1;
          mwe_q    <= a_we;
          maddr_q  <= base;
          mstrb_q  <= a_we ? strb8[3:0] : 4'b0000;
          mwdata_q <= a_we ? lanes[31:0] : 32'b0;
        end
        REQ1: begin
          mreq_q   <= 1'b1;
          mwe_q    <= a_we;
          maddr_q  <= base + 32'd4;
          mstrb_q  <= a_we ? strb8[7:4] : 4'b0000;
          mwdata_q <= a_we ? lanes[63:32] : 32'b0;
        end
        default: begin
          mreq_q   <= 1'b0;
          mwe_q    <= 1'b0;
          maddr_q  <= '0;
          mstrb_q  <= '0;
          mwdata_q <= '0;
        end
      endcase
      if (state_n == RESP) begin
        rvld_q  <= 1'b1;
        rerr_q  <= !legal;
        rrd_q   <= a_we ? 5'd0 : a_rd;
        rdata_q <= (!legal || a_we) ? 32'b0 : ext;
      end else begin
        rvld_q  <= 1'b0;
        rerr_q  <= 1'b0;
        rrd_q   <= '0;
        rdata_q <= '0;
      end
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.mem_req    = mreq_q;
  assign bus.mem_we     = mwe_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_wstrb  = mstrb_q;
  assign bus.mem_wdata  = mwdata_q;
  assign bus.resp_valid = rvld_q;
  assign bus.resp_rd    = rrd_q;
  assign bus.resp_data  = rdata_q;
  assign bus.resp_err   = rerr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: aligned/misaligned loads and stores, wrap,
// grant stalls, illegal func3 and mid-transaction reset.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if bus ();

  lsu_ctrl u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a request for exactly one accepting edge; returns 1ns after it
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_func3 = f3;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_rd    = rd;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic load_al(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'h0, rd);
    bus.mem_gnt = 1'b1;
    chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'd1);
    chk({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
    chk({tag, ".wstrb"}, 32'(bus.mem_wstrb), 32'd0);
    chk({tag, ".busy"}, 32'(bus.req_ready), 32'd0);
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    chk({tag, ".req_drop"}, 32'(bus.mem_req), 32'd0);
    tick();
    bus.mem_rvalid = 1'b0;
    chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, ".resp_data"}, bus.resp_data, exp);
    chk({tag, ".resp_rd"}, 32'(bus.resp_rd), 32'(rd));
    chk({tag, ".resp_err"}, 32'(bus.resp_err), 32'd0);
    tick();
    chk({tag, ".pulse_end"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic store_al(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wdata, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata);
    issue(1'b1, f3, addr, wdata, 5'd3);
    bus.mem_gnt = 1'b1;
    chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'd1);
    chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'd1);
    chk({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
    chk({tag, ".wstrb"}, 32'(bus.mem_wstrb), 32'(exp_strb));
    chk({tag, ".wdata"}, bus.mem_wdata, exp_wdata);
    tick();
    bus.mem_gnt = 1'b0;
    chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, ".resp_rd"}, 32'(bus.resp_rd), 32'd0);
    chk({tag, ".resp_data"}, bus.resp_data, 32'd0);
    chk({tag, ".req_drop"}, 32'(bus.mem_req), 32'd0);
    tick();
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_func3  = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_rd     = 5'd0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;

    tick();
    tick();
    chk("rst.ready", 32'(bus.req_ready), 32'd1);
    chk("rst.mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst.mem_addr", bus.mem_addr, 32'd0);
    chk("rst.wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst.wdata", bus.mem_wdata, 32'd0);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.resp_rd", 32'(bus.resp_rd), 32'd0);
    chk("rst.resp_data", bus.resp_data, 32'd0);
    chk("rst.resp_err", 32'(bus.resp_err), 32'd0);
    rst_n = 1'b1;
    tick();

    load_al("lw",  32'h100, F3_W,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF);
    load_al("lb",  32'h103, F3_B,  5'd6,  32'h80112233, 32'hFFFFFF80);
    load_al("lbu", 32'h103, F3_BU, 5'd7,  32'h80112233, 32'h00000080);
    load_al("lh",  32'h102, F3_H,  5'd8,  32'h80010000, 32'hFFFF8001);
    load_al("lhu", 32'h102, F3_HU, 5'd9,  32'h80010000, 32'h00008001);

    // misaligned LW spanning 0x100/0x104
    issue(1'b0, F3_W, 32'h102, 32'h0, 5'd10);
    bus.mem_gnt = 1'b1;
    chk("mlw.addr0", bus.mem_addr, 32'h100);
    tick();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h44332211;
    tick();
    bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b1;
    chk("mlw.req1", 32'(bus.mem_req), 32'd1);
    chk("mlw.addr1", bus.mem_addr, 32'h104);
    chk("mlw.no_resp_yet", 32'(bus.resp_valid), 32'd0);
    tick();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h88776655;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("mlw.resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("mlw.resp_data", bus.resp_data, 32'h66554433);
    chk("mlw.resp_rd", 32'(bus.resp_rd), 32'd10);
    tick();

    // split SH at offset 3
    issue(1'b1, F3_H, 32'h003, 32'h0000ABCD, 5'd7);
    bus.mem_gnt = 1'b1;
    chk("sh.addr0", bus.mem_addr, 32'h000);
    chk("sh.strb0", 32'(bus.mem_wstrb), 32'h8);
    chk("sh.wdata0", bus.mem_wdata, 32'hCD000000);
    tick();
    chk("sh.req1", 32'(bus.mem_req), 32'd1);
    chk("sh.addr1", bus.mem_addr, 32'h004);
    chk("sh.strb1", 32'(bus.mem_wstrb), 32'h1);
    chk("sh.wdata1", bus.mem_wdata, 32'h000000AB);
    tick();
    bus.mem_gnt = 1'b0;
    chk("sh.resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("sh.resp_rd", 32'(bus.resp_rd), 32'd0);
    tick();

    // split SW across the top of the address space with a stalled grant
    issue(1'b1, F3_W, 32'hFFFFFFFE, 32'h11223344, 5'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("swr.stall%0d.req", i), 32'(bus.mem_req), 32'd1);
      chk($sformatf("swr.stall%0d.addr", i), bus.mem_addr, 32'hFFFFFFFC);
      chk($sformatf("swr.stall%0d.strb", i), 32'(bus.mem_wstrb), 32'hC);
      chk($sformatf("swr.stall%0d.wdata", i), bus.mem_wdata, 32'h33440000);
      chk($sformatf("swr.stall%0d.we", i), 32'(bus.mem_we), 32'd1);
      tick();
    end
    bus.mem_gnt = 1'b1;
    chk("swr.addr0_at_gnt", bus.mem_addr, 32'hFFFFFFFC);
    tick();
    chk("swr.addr1", bus.mem_addr, 32'h00000000);
    chk("swr.strb1", 32'(bus.mem_wstrb), 32'h3);
    chk("swr.wdata1", bus.mem_wdata, 32'h00001122);
    tick();
    bus.mem_gnt = 1'b0;
    chk("swr.resp_valid", 32'(bus.resp_valid), 32'd1);
    tick();

    // illegal load func3: straight to completion, no memory traffic
    issue(1'b0, 3'b011, 32'h40, 32'h0, 5'd4);
    chk("ill.mem_req", 32'(bus.mem_req), 32'd0);
    chk("ill.resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("ill.resp_err", 32'(bus.resp_err), 32'd1);
    chk("ill.resp_data", bus.resp_data, 32'd0);
    tick();
    chk("ill.pulse_end", 32'(bus.resp_valid), 32'd0);

    // reset while waiting for read data; the late rvalid must be ignored
    issue(1'b0, F3_W, 32'h200, 32'h0, 5'd9);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
    chk("rstw.ready", 32'(bus.req_ready), 32'd1);
    chk("rstw.mem_req", 32'(bus.mem_req), 32'd0);
    chk("rstw.resp0", 32'(bus.resp_valid), 32'd0);
    tick();
    bus.mem_rvalid = 1'b0;
    chk("rstw.resp1", 32'(bus.resp_valid), 32'd0);
    chk("rstw.mem_req1", 32'(bus.mem_req), 32'd0);
    tick();
    chk("rstw.resp2", 32'(bus.resp_valid), 32'd0);

    store_al("sw", 32'h10, F3_W, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D);
    store_al("sb", 32'h21, F3_B, 32'h000000EE, 4'h2, 32'h0000EE00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencing controller between the execute stage and the 32-bit data-memory port. Accepts one load or store per handshake, drives word-aligned memory requests with byte strobes, and splits misaligned accesses into two word transactions. Load bytes are merged, shifted and sign/zero-extended by func3. A single completion per request is returned to writeback.

## Interface
- No parameters; data path fixed at 32 bits, register index 5 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_func3  in  3  RV32I load/store func3
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-justified
- req_rd  in  5  load destination register
- mem_req  out  1  memory request, held until granted
- mem_we  out  1  write request
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_wstrb  out  4  byte strobes, 0 for reads
- mem_wdata  out  32  lane-aligned write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid, at least 1 cycle after grant
- mem_rdata  in  32  read data
- resp_valid  out  1  one-cycle completion pulse
- resp_rd  out  5  destination; 0 for stores
- resp_data  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal func3

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- Request is accepted on req_valid && req_ready. addr, func3, we, wdata and rd are latched.
- Size comes from func3[1:0]: 1, 2 or 4 bytes.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
- Illegal func3: IDLE → RESP with no memory access; resp_err=1, resp_data=0.
- off = addr[1:0]. split = off + size > 4.
- First access targets {addr[31:2],2'b00}. The second targets that address + 4, wrapping modulo 2^32, so 0xFFFF_FFFC is followed by 0x0000_0000.
- Store lanes: 64-bit data = wdata << 8*off; 8-bit strobe = sizemask << off. The low half goes to access 0 and the high half to access 1.
- Load merge: {rdata1, rdata0} >> 8*off, take the low 32 bits, then extend. Non-split loads use rdata0 only.
- REQ0: mem_req=1 until mem_gnt.
  - Load → WAIT0.
  - Store → REQ1 if split, else RESP. Stores need no rvalid.
- WAIT0: on mem_rvalid, capture rdata0 → REQ1 if split, else RESP.
- REQ1/WAIT1 behave as REQ0/WAIT0 for the second word. Both exit to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- mem_rvalid outside WAIT0/WAIT1 is ignored.

## Timing
- Reset values: state IDLE; req_ready=1; mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0; resp_valid=0, resp_rd=0, resp_data=0, resp_err=0.
- rst_n low at any state aborts the transaction: mem_req drops the next edge and no response is produced.
- All outputs are registered. req_ready=1 only in IDLE.
- Aligned load, zero-wait memory (gnt in the request cycle, rvalid the next cycle): accept at T0, mem_req at T1, rvalid at T2, resp_valid at T3.
- Aligned store, immediate gnt: accept T0, mem_req T1, resp_valid T2.
- Split adds 2 cycles for loads and 1 for stores.
- mem_addr, mem_we, mem_wstrb and mem_wdata are stable while mem_req=1 and not granted.
- A new request is accepted no earlier than the cycle after RESP.

## Structure
- Package lsu_pkg holds:
  - func3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - state enum
  - size decode function
- Sub-module load_ext: combinational func3 + 32-bit merged data → extended result, all-zero for illegal func3. It is instantiated once, on the merged load word.

## Test plan
- LW addr 0x100, rdata 0xDEADBEEF, gnt immediate → resp at T3: data 0xDEADBEEF, rd as issued.
- LB addr 0x103, rdata 0x80112233 → 0xFFFFFF80. LBU same → 0x00000080.
- Misaligned LW addr 0x102: words 0x44332211 @0x100, 0x88776655 @0x104 → two requests, resp 0x66554433.
- SH addr 0x003, wdata 0x0000ABCD:
  - access 0: addr 0x000, wstrb 1000, wdata 0xCD000000
  - access 1: addr 0x004, wstrb 0001, wdata 0x000000AB
- SW addr 0xFFFFFFFE → second access at 0x00000000; mem_gnt held low 3 cycles with request fields stable throughout.
- Load func3=011 → no mem_req, resp_err=1, data 0. rst_n low during WAIT0 → IDLE, late rvalid ignored, no resp_valid.
